alu_exec_unit: RTL and testbench

- Execute-stage ALU core of the 8-bit pipelined processor.
- Consumes the two operands produced by the operand-select muxes (A or 0, B or 1) plus a decoded opcode.
- Produces a registered ALU_OUT for the result-select mux, and maintains the condition-code register.
- Single-cycle ops complete in one clock. MUL is a serial shift-add over 8 iterations and asserts BUSY so the hazard unit stalls upstream.

---
 rtl/alu_exec_unit_if.sv | 25 ++
 rtl/alu_exec_unit.sv | 190 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Execute-stage ALU request/result bundle: operands and opcode in; result, flags and status out.
// The master drives requests and the slave (the ALU) returns registered results.
interface alu_exec_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] alu_out_hi;
    logic             out_valid;
    logic             busy;
    logic [3:0]       flags;

    modport master (
        output in_valid, opcode, op_a, op_b,
        input  alu_out, alu_out_hi, out_valid, busy, flags
    );

    modport slave (
        input  in_valid, opcode, op_a, op_b,
        output alu_out, alu_out_hi, out_valid, busy, flags
    );
endinterface

// File: rtl/alu_exec_unit.sv
// 8-bit execute ALU with {Z,N,C,V} flags; ALU_MUL_EN adds a serial 8-iteration unsigned multiply.
// Single-cycle ops: 1 clock. MUL: 9 clocks with busy high; requests seen while busy are dropped.
module alu_exec_unit #(
    parameter int WIDTH    = 8,
    parameter int MUL_ITER = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave io
);
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_ADC = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_SBC = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_RLC = 4'hB;
    localparam logic [3:0] OP_RRC = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_CMP = 4'hE;

    if (WIDTH != 8 || MUL_ITER != WIDTH) begin : g_param_check
        $error("alu_exec_unit supports only WIDTH=8 and MUL_ITER=WIDTH");
    end

    logic [WIDTH-1:0] out_q;
    logic [3:0]       flags_q;
    logic             out_vld_q;
    logic             busy_w;
    logic             accept;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   add9;
    logic [WIDTH:0]   sub9;
    logic             c_n;
    logic             v_n;
    logic             wr_out;
    logic             wr_flags;

    assign a      = io.op_a;
    assign b      = io.op_b;
    assign c_in   = flags_q[1];
    assign accept = io.in_valid && !busy_w;

    always_comb begin
        res      = out_q;
        c_n      = c_in;
        v_n      = 1'b0;
        wr_out   = 1'b0;
        wr_flags = 1'b0;
        add9     = '0;
        sub9     = '0;
        case (io.opcode)
            OP_ADD, OP_ADC: begin
                add9     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (io.opcode == OP_ADC) & c_in};
                res      = add9[WIDTH-1:0];
                c_n      = add9[WIDTH];
                v_n      = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
                wr_out   = 1'b1;
                wr_flags = 1'b1;
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                // bit 8 of the 9-bit difference is the borrow
                sub9     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (io.opcode == OP_SBC) & c_in};
                res      = sub9[WIDTH-1:0];
                c_n      = sub9[WIDTH];
                v_n      = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
                wr_out   = (io.opcode != OP_CMP);
                wr_flags = 1'b1;
            end
            OP_AND: begin res = a & b; wr_out = 1'b1; wr_flags = 1'b1; end
            OP_OR:  begin res = a | b; wr_out = 1'b1; wr_flags = 1'b1; end
            OP_XOR: begin res = a ^ b; wr_out = 1'b1; wr_flags = 1'b1; end
            OP_NOT: begin res = ~a;    wr_out = 1'b1; wr_flags = 1'b1; end
            OP_SHL: begin
                res = {a[WIDTH-2:0], 1'b0}; c_n = a[WIDTH-1]; wr_out = 1'b1; wr_flags = 1'b1;
            end
            OP_SHR: begin
                res = {1'b0, a[WIDTH-1:1]}; c_n = a[0]; wr_out = 1'b1; wr_flags = 1'b1;
            end
            OP_RLC: begin
                res = {a[WIDTH-2:0], c_in}; c_n = a[WIDTH-1]; wr_out = 1'b1; wr_flags = 1'b1;
            end
            OP_RRC: begin
                res = {c_in, a[WIDTH-1:1]}; c_n = a[0]; wr_out = 1'b1; wr_flags = 1'b1;
            end
            OP_NOP, OP_MUL: begin end
            default: begin end
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {IDLE, MUL_RUN} state_t;

    localparam logic [3:0] LAST_ITER = 4'(MUL_ITER - 1);

    state_t             state_q;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   mplier_q;
    logic [3:0]         cnt_q;

    assign busy_w   = busy_q;
    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            out_q     <= '0;
            hi_q      <= '0;
            flags_q   <= '0;
            out_vld_q <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            out_vld_q <= 1'b0;
            if (state_q == IDLE) begin
                if (accept && io.opcode == OP_MUL) begin
                    state_q  <= MUL_RUN;
                    busy_q   <= 1'b1;
                    mcand_q  <= {{WIDTH{1'b0}}, a};
                    mplier_q <= b;
                    prod_q   <= '0;
                    cnt_q    <= '0;
                end
                if (accept && wr_flags) flags_q <= {res == '0, res[WIDTH-1], c_n, v_n};
                if (accept && wr_out) begin
                    out_q     <= res;
                    hi_q      <= '0;
                    out_vld_q <= 1'b1;
                end
            end else begin
                prod_q   <= prod_nxt;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 4'd1;
                if (cnt_q == LAST_ITER) begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    out_vld_q <= 1'b1;
                    out_q     <= prod_nxt[WIDTH-1:0];
                    hi_q      <= prod_nxt[2*WIDTH-1:WIDTH];
                    flags_q   <= {prod_nxt == '0, prod_nxt[2*WIDTH-1],
                                  prod_nxt[2*WIDTH-1:WIDTH] != '0, 1'b0};
                end
            end
        end
    end

    assign io.alu_out_hi = hi_q;
`else
    assign busy_w = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q     <= '0;
            flags_q   <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= 1'b0;
            if (accept && wr_flags) flags_q <= {res == '0, res[WIDTH-1], c_n, v_n};
            if (accept && wr_out) begin
                out_q     <= res;
                out_vld_q <= 1'b1;
            end
        end
    end

    assign io.alu_out_hi = '0;
`endif

    assign io.alu_out   = out_q;
    assign io.flags     = flags_q;
    assign io.out_valid = out_vld_q;
    assign io.busy      = busy_w;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops, hand sequences for reset and MUL.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(8)) bus ();

    alu_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic       vld;
        logic [3:0] fl;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] out, input logic [7:0] hi,
                               input logic vld, input logic bsy, input logic [3:0] fl);
        check({tag, " out"},   {8'h00, bus.alu_out},    {8'h00, out});
        check({tag, " hi"},    {8'h00, bus.alu_out_hi}, {8'h00, hi});
        check({tag, " vld"},   {15'h0, bus.out_valid},  {15'h0, vld});
        check({tag, " busy"},  {15'h0, bus.busy},       {15'h0, bsy});
        check({tag, " flags"}, {12'h0, bus.flags},      {12'h0, fl});
    endtask

`ifdef ALU_MUL_EN
    // MUL accepted at edge t, then an ADD 01+02 is held on the bus throughout and must land at t+9
    task automatic mul_seq(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] lo, input logic [7:0] hi, input logic [3:0] fl);
        bus.opcode   = 4'hD;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        step();
        bus.opcode = 4'h1;
        bus.op_a   = 8'h01;
        bus.op_b   = 8'h02;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s run%0d busy", tag, i), {15'h0, bus.busy}, 16'h0001);
            check($sformatf("%s run%0d vld", tag, i), {15'h0, bus.out_valid}, 16'h0000);
            step();
        end
        check_state({tag, " done"}, lo, hi, 1'b1, 1'b0, fl);
        step();
        bus.in_valid = 1'b0;
        check_state({tag, " held add"}, 8'h03, 8'h00, 1'b1, 1'b0, 4'b0000);
        step();
    endtask
`endif

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.opcode   = 4'h0;
        bus.op_a     = 8'h00;
        bus.op_b     = 8'h00;

        //              op     a      b      out    vld   {Z,N,C,V}
        vecs[0]  = '{4'h1, 8'h7F, 8'h01, 8'h80, 1'b1, 4'b0101};
        vecs[1]  = '{4'h1, 8'hFF, 8'h01, 8'h00, 1'b1, 4'b1010};
        vecs[2]  = '{4'h2, 8'h01, 8'h01, 8'h03, 1'b1, 4'b0000};
        vecs[3]  = '{4'h3, 8'h05, 8'h07, 8'hFE, 1'b1, 4'b0110};
        vecs[4]  = '{4'hE, 8'h07, 8'h07, 8'hFE, 1'b0, 4'b1000};
        vecs[5]  = '{4'h0, 8'h12, 8'h34, 8'hFE, 1'b0, 4'b1000};
        vecs[6]  = '{4'h9, 8'h81, 8'h00, 8'h02, 1'b1, 4'b0010};
        vecs[7]  = '{4'hB, 8'h80, 8'h00, 8'h01, 1'b1, 4'b0010};
        vecs[8]  = '{4'h5, 8'h3C, 8'h0F, 8'h0C, 1'b1, 4'b0010};
        vecs[9]  = '{4'h4, 8'h10, 8'h0F, 8'h00, 1'b1, 4'b1000};
        vecs[10] = '{4'h3, 8'h80, 8'h01, 8'h7F, 1'b1, 4'b0001};
        vecs[11] = '{4'h6, 8'h50, 8'h05, 8'h55, 1'b1, 4'b0000};
        vecs[12] = '{4'h7, 8'hFF, 8'h0F, 8'hF0, 1'b1, 4'b0100};
        vecs[13] = '{4'h8, 8'h0F, 8'hAA, 8'hF0, 1'b1, 4'b0100};
        vecs[14] = '{4'hA, 8'h01, 8'h00, 8'h00, 1'b1, 4'b1010};
        vecs[15] = '{4'hC, 8'h02, 8'h00, 8'h81, 1'b1, 4'b0100};
        vecs[16] = '{4'hF, 8'h55, 8'h66, 8'h81, 1'b0, 4'b0100};
        vecs[17] = '{4'h4, 8'h00, 8'h00, 8'h00, 1'b1, 4'b1000};
        vecs[18] = '{4'h3, 8'h00, 8'h01, 8'hFF, 1'b1, 4'b0110};
        vecs[19] = '{4'h4, 8'h00, 8'h00, 8'hFF, 1'b1, 4'b0110};
        vecs[20] = '{4'h2, 8'h7F, 8'h00, 8'h80, 1'b1, 4'b0101};
        vecs[21] = '{4'h1, 8'h80, 8'h80, 8'h00, 1'b1, 4'b1011};

        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.opcode   = 4'($urandom_range(0, 15));
            bus.op_a     = 8'($urandom_range(0, 255));
            bus.op_b     = 8'($urandom_range(0, 255));
            step();
        end
        rst = 1'b0;
        step();
        step();
        check_state("reset", 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            bus.opcode   = vecs[i].op;
            bus.op_a     = vecs[i].a;
            bus.op_b     = vecs[i].b;
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            check_state($sformatf("v%0d", i), vecs[i].out, 8'h00, vecs[i].vld, 1'b0, vecs[i].fl);
            step();
            check($sformatf("v%0d pulse", i), {15'h0, bus.out_valid}, 16'h0000);
            check($sformatf("v%0d hold", i), {8'h00, bus.alu_out}, {8'h00, vecs[i].out});
        end

`ifdef ALU_MUL_EN
        mul_seq("mul c8x0a", 8'hC8, 8'h0A, 8'hD0, 8'h07, 4'b0010);
        mul_seq("mul ffxff", 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0110);
        mul_seq("mul 00x55", 8'h00, 8'h55, 8'h00, 8'h00, 4'b1000);

        bus.opcode   = 4'hD;
        bus.op_a     = 8'h12;
        bus.op_b     = 8'h34;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        check("mulrst pre busy", {15'h0, bus.busy}, 16'h0001);
        rst = 1'b0;
        step();
        check_state("mulrst", 8'h00, 8'h00, 1'b0, 1'b0, 4'b0000);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("mulrst after%0d vld", i), {15'h0, bus.out_valid}, 16'h0000);
            check($sformatf("mulrst after%0d busy", i), {15'h0, bus.busy}, 16'h0000);
        end
`else
        bus.opcode   = 4'hD;
        bus.op_a     = 8'h12;
        bus.op_b     = 8'h34;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state($sformatf("nomul%0d", i), 8'h00, 8'h00, 1'b0, 1'b0, 4'b1011);
        end
        bus.in_valid = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
